// File: rtl/parallel_to_serial_if.sv
// rtl/parallel_to_serial_if.sv - parallel block input / serial sample output bundle
interface parallel_to_serial_if #(
    parameter int P_SIZE = 16,
    parameter int DATA_W = 9
);
    logic signed [DATA_W-1:0] data_in_i [P_SIZE-1:0];
    logic signed [DATA_W-1:0] data_in_q [P_SIZE-1:0];
    logic                     valid_in;
    logic signed [DATA_W-1:0] data_out_i;
    logic signed [DATA_W-1:0] data_out_q;
    logic                     valid_out;
    logic                     sop_out;
    logic                     eop_out;
    logic                     overflow;

    modport master (
        output data_in_i, data_in_q, valid_in,
        input  data_out_i, data_out_q, valid_out, sop_out, eop_out, overflow
    );

    modport slave (
        input  data_in_i, data_in_q, valid_in,
        output data_out_i, data_out_q, valid_out, sop_out, eop_out, overflow
    );
endinterface

// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - ping-pong buffered parallel I/Q block to serial stream
module parallel_to_serial #(
    parameter int P_SIZE = 16,
    parameter int DATA_W = 9
) (
    input  logic                 clk,
    input  logic                 rstn,
    parallel_to_serial_if.slave  bus
);
    localparam int CW = $clog2(P_SIZE);
    localparam logic [CW-1:0] LAST = CW'(P_SIZE - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            cnt;
    logic [1:0]               full, full_nxt;
    logic                     wr_sel, rd_sel;
    logic                     rel, cap, drop;
    logic signed [DATA_W-1:0] bank_i [2][P_SIZE];
    logic signed [DATA_W-1:0] bank_q [2][P_SIZE];
    logic signed [DATA_W-1:0] out_i, out_q;
    logic                     out_v, out_sop, out_eop, ovf;

    // A block may land in the bank being drained on the very edge its last sample leaves
    always_comb begin
        rel      = (state == S_ACTIVE) && (cnt == LAST);
        cap      = bus.valid_in && (!full[wr_sel] || (rel && (rd_sel == wr_sel)));
        drop     = bus.valid_in && !cap;
        full_nxt = full;
        if (rel) full_nxt[rd_sel] = 1'b0;
        if (cap) full_nxt[wr_sel] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (full[rd_sel]) state_nxt = S_ACTIVE;
            S_ACTIVE: if (rel && !(full[~rd_sel] || (cap && (wr_sel != rd_sel))))
                          state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            for (int k = 0; k < P_SIZE; k++) begin
                bank_i[wr_sel][k] <= bus.data_in_i[k];
                bank_q[wr_sel][k] <= bus.data_in_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full    <= 2'b00;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            cnt     <= '0;
            out_i   <= '0;
            out_q   <= '0;
            out_v   <= 1'b0;
            out_sop <= 1'b0;
            out_eop <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            full <= full_nxt;
            if (cap)  wr_sel <= ~wr_sel;
            if (rel)  rd_sel <= ~rd_sel;
            if (drop) ovf    <= 1'b1;
            if (state == S_ACTIVE) begin
                out_i   <= bank_i[rd_sel][cnt];
                out_q   <= bank_q[rd_sel][cnt];
                out_v   <= 1'b1;
                out_sop <= (cnt == '0);
                out_eop <= (cnt == LAST);
                cnt     <= cnt + CW'(1);
            end else if (full[rd_sel]) begin
                // Idle start: sample 0 goes out on the same edge the block is noticed
                out_i   <= bank_i[rd_sel][0];
                out_q   <= bank_q[rd_sel][0];
                out_v   <= 1'b1;
                out_sop <= 1'b1;
                out_eop <= 1'b0;
                cnt     <= CW'(1);
            end else begin
                out_v   <= 1'b0;
                out_sop <= 1'b0;
                out_eop <= 1'b0;
            end
        end
    end

    assign bus.data_out_i = out_i;
    assign bus.data_out_q = out_q;
    assign bus.valid_out  = out_v;
    assign bus.sop_out    = out_sop;
    assign bus.eop_out    = out_eop;
    assign bus.overflow   = ovf;
endmodule
